// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   ByteW     - width of every host byte, opcode and operand
//   St*       - loader FSM state encoding
package prog_loader_pkg;

    localparam int unsigned ByteW = 8;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLen   = 3'd1;
    localparam logic [2:0] StOpc   = 3'd2;
    localparam logic [2:0] StOpd   = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;
    localparam logic [2:0] StChk   = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;
    localparam logic [2:0] StErr   = 3'd7;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus program-memory write bus of the program loader.
//   in_valid/in_data/in_ready        - host byte handshake
//   pm_we/pm_addr/pm_opcode/pm_operand - program memory write port
// Modports: master = host / memory side, slave = loader side.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();
    import prog_loader_pkg::*;

    logic              in_valid;
    logic [ByteW-1:0]  in_data;
    logic              in_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [ByteW-1:0]  pm_opcode;
    logic [ByteW-1:0]  pm_operand;

    modport master (
        output in_valid, in_data,
        input  in_ready, pm_we, pm_addr, pm_opcode, pm_operand
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, pm_we, pm_addr, pm_opcode, pm_operand
    );

endinterface

// File: rtl/loader_cksum.sv
// 8-bit modulo-256 running-sum accumulator for the load stream.
//   clk, rst - clock, synchronous active-high reset
//   clr      - restart the sum at 0 (new session)
//   add_en   - add data into the sum this cycle
//   data     - byte being accepted
//   sum_ok   - sum including the current data byte is 0
module loader_cksum
    import prog_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ByteW-1:0] data,
    output logic             sum_ok
);

    logic [ByteW-1:0] sum_q;
    logic [ByteW-1:0] sum_d;

    // Look-ahead so the CHK byte can be judged in the same cycle it arrives.
    assign sum_d  = sum_q + data;
    assign sum_ok = (sum_d == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams {LEN, N x (opcode, operand), CHK} from a host into program memory
// while holding the processor core, then verifies the modulo-256 checksum.
//   clk, rst  - clock, synchronous active-high reset
//   start     - one-cycle pulse, begins a session from IDLE, DONE or ERR
//   bus       - host byte handshake and program memory write port (slave)
//   cpu_hold  - freezes the core's PC/pipeline while a session is open
//   busy      - session active (IDLE excluded)
//   done      - one-cycle success pulse
//   err       - checksum failure, held until the next start or rst
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ByteW-1:0]  opc_q, opd_q, cnt_q;
    logic              rdy;
    logic              xfer;
    logic              start_acc;
    logic              sum_ok;

    assign rdy  = (state_q == StLen) || (state_q == StOpc) ||
                  (state_q == StOpd) || (state_q == StChk);
    assign xfer = bus.in_valid && rdy;

    // start only opens a session from a resting state.
    assign start_acc = start &&
        ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));

    loader_cksum u_cksum (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc),
        .add_en (xfer),
        .data   (bus.in_data),
        .sum_ok (sum_ok)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StLen;
            StLen:   if (xfer) state_d = (bus.in_data == '0) ? StChk : StOpc;
            StOpc:   if (xfer) state_d = StOpd;
            StOpd:   if (xfer) state_d = StWrite;
            // cnt_q holds the writes still owed, including this one.
            StWrite: state_d = (cnt_q == ByteW'(1)) ? StChk : StOpc;
            StChk:   if (xfer) state_d = sum_ok ? StDone : StErr;
            StDone:  state_d = start ? StLen : StIdle;
            StErr:   if (start) state_d = StLen;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            opc_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (start_acc) begin
                addr_q <= BaseAddr;
            end else if (state_q == StWrite) begin
                addr_q <= addr_q + 1'b1;  // wraps silently
            end

            if (state_q == StLen && xfer) begin
                cnt_q <= bus.in_data;
            end else if (state_q == StWrite) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (state_q == StOpc && xfer) opc_q <= bus.in_data;
            if (state_q == StOpd && xfer) opd_q <= bus.in_data;
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.pm_we      = (state_q == StWrite);
    assign bus.pm_addr    = addr_q;
    assign bus.pm_opcode  = opc_q;
    assign bus.pm_operand = opd_q;

    assign busy     = (state_q != StIdle);
    assign cpu_hold = busy;
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a per-cycle vector table on a
// BASE_ADDR=0 instance, plus a hand-written wrap/backpressure session on a
// BASE_ADDR=FE instance.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic hold0, busy0, done0, err0;
    logic hold1, busy1, done1, err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(8)) bus0 ();
    prog_loader_if #(.ADDR_W(8)) bus1 ();

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .bus      (bus0),
        .cpu_hold (hold0),
        .busy     (busy0),
        .done     (done0),
        .err      (err0)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .bus      (bus1),
        .cpu_hold (hold1),
        .busy     (busy1),
        .done     (done1),
        .err      (err1)
    );

    // ctl = {rst, start, in_valid}; flags = {in_ready, pm_we, busy, done, err}
    typedef struct {
        logic [2:0] ctl;
        logic [7:0] data;
        logic [4:0] flags;
        logic [7:0] addr;
        logic [7:0] opc;
        logic [7:0] opd;
    } vec_t;

    vec_t vecs[$];

    // Write log of dut1, filled by the monitor below.
    logic [7:0] w_addr[$];
    logic [7:0] w_opc[$];
    logic [7:0] w_opd[$];
    logic       w_rdy[$];
    int         done1_cnt  = 0;
    logic       err1_seen  = 1'b0;

    always @(negedge clk) begin
        if (bus1.pm_we === 1'b1) begin
            w_addr.push_back(bus1.pm_addr);
            w_opc.push_back(bus1.pm_opcode);
            w_opd.push_back(bus1.pm_operand);
            w_rdy.push_back(bus1.in_ready);
        end
        if (done1 === 1'b1) done1_cnt++;
        if (err1 === 1'b1) err1_seen = 1'b1;
    end

    task automatic add(input logic [2:0] ctl, input logic [7:0] data, input logic [4:0] flags,
                       input logic [7:0] addr, input logic [7:0] opc, input logic [7:0] opd);
        vec_t v;
        v.ctl = ctl; v.data = data; v.flags = flags;
        v.addr = addr; v.opc = opc; v.opd = opd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    // Offer one byte to dut1 after `gap` idle cycles; bounded wait for in_ready.
    task automatic send1(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus1.in_valid = 1'b0;
            @(negedge clk);
            check("stall_ready", g, 32'(bus1.in_ready), 32'd1);
            check("stall_we", g, 32'(bus1.pm_we), 32'd0);
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b1;
        bus1.in_data  = b;
        n = 0;
        @(negedge clk);
        while (bus1.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", int'(b), 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_a[3];
        logic [7:0] exp_o[3];
        logic [7:0] exp_d[3];
        int n;

        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;

        // Clean load: 02+10+05+20+07 = 3E, so C2 closes the sum to 0x100.
        add(3'b010, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h02, 5'b10100, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h10, 5'b10100, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h05, 5'b10100, 8'h00, 8'h10, 8'h00);
        add(3'b000, 8'h00, 5'b01100, 8'h00, 8'h10, 8'h05);
        add(3'b001, 8'h20, 5'b10100, 8'h01, 8'h10, 8'h05);
        add(3'b001, 8'h07, 5'b10100, 8'h01, 8'h20, 8'h05);
        add(3'b000, 8'h00, 5'b01100, 8'h01, 8'h20, 8'h07);
        add(3'b001, 8'hC2, 5'b10100, 8'h02, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00110, 8'h02, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00000, 8'h02, 8'h20, 8'h07);
        // Zero length: no write, straight to CHK.
        add(3'b010, 8'h00, 5'b00000, 8'h02, 8'h20, 8'h07);
        add(3'b001, 8'h00, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b001, 8'h00, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00110, 8'h00, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00000, 8'h00, 8'h20, 8'h07);
        // Bad checksum: both writes land, err sticks with core held.
        add(3'b010, 8'h00, 5'b00000, 8'h00, 8'h20, 8'h07);
        add(3'b001, 8'h02, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b001, 8'h10, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b001, 8'h05, 5'b10100, 8'h00, 8'h10, 8'h07);
        add(3'b000, 8'h00, 5'b01100, 8'h00, 8'h10, 8'h05);
        add(3'b001, 8'h20, 5'b10100, 8'h01, 8'h10, 8'h05);
        add(3'b001, 8'h07, 5'b10100, 8'h01, 8'h20, 8'h05);
        add(3'b000, 8'h00, 5'b01100, 8'h01, 8'h20, 8'h07);
        add(3'b001, 8'hC3, 5'b10100, 8'h02, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00101, 8'h02, 8'h20, 8'h07);
        add(3'b000, 8'h00, 5'b00101, 8'h02, 8'h20, 8'h07);
        // start from ERR; a second start during OPD is ignored. 01+AA+55 = 0x100.
        add(3'b010, 8'h00, 5'b00101, 8'h02, 8'h20, 8'h07);
        add(3'b001, 8'h01, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b001, 8'hAA, 5'b10100, 8'h00, 8'h20, 8'h07);
        add(3'b011, 8'h55, 5'b10100, 8'h00, 8'hAA, 8'h07);
        add(3'b000, 8'h00, 5'b01100, 8'h00, 8'hAA, 8'h55);
        add(3'b001, 8'h00, 5'b10100, 8'h01, 8'hAA, 8'h55);
        add(3'b000, 8'h00, 5'b00110, 8'h01, 8'hAA, 8'h55);
        add(3'b000, 8'h00, 5'b00000, 8'h01, 8'hAA, 8'h55);
        // Reset in the first WRITE, then a clean N=1 load (01+33+44 = 78, CHK 88).
        add(3'b010, 8'h00, 5'b00000, 8'h01, 8'hAA, 8'h55);
        add(3'b001, 8'h02, 5'b10100, 8'h00, 8'hAA, 8'h55);
        add(3'b001, 8'h11, 5'b10100, 8'h00, 8'hAA, 8'h55);
        add(3'b001, 8'h22, 5'b10100, 8'h00, 8'h11, 8'h55);
        add(3'b100, 8'h00, 5'b01100, 8'h00, 8'h11, 8'h22);
        add(3'b010, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h01, 5'b10100, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h33, 5'b10100, 8'h00, 8'h00, 8'h00);
        add(3'b001, 8'h44, 5'b10100, 8'h00, 8'h33, 8'h00);
        add(3'b000, 8'h00, 5'b01100, 8'h00, 8'h33, 8'h44);
        add(3'b001, 8'h88, 5'b10100, 8'h01, 8'h33, 8'h44);
        add(3'b000, 8'h00, 5'b00110, 8'h01, 8'h33, 8'h44);
        // rst wins over start in the same cycle.
        add(3'b110, 8'h00, 5'b00000, 8'h01, 8'h33, 8'h44);
        add(3'b000, 8'h00, 5'b00000, 8'h00, 8'h00, 8'h00);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].ctl[2];
            start0        = vecs[i].ctl[1];
            bus0.in_valid = vecs[i].ctl[0];
            bus0.in_data  = vecs[i].data;
            @(negedge clk);
            check("vec_flags", i,
                  32'({bus0.in_ready, bus0.pm_we, busy0, done0, err0}), 32'(vecs[i].flags));
            check("vec_hold", i, 32'(hold0), 32'(vecs[i].flags[2]));
            check("vec_bus", i, 32'({bus0.pm_addr, bus0.pm_opcode, bus0.pm_operand}),
                  32'({vecs[i].addr, vecs[i].opc, vecs[i].opd}));
            @(posedge clk);
            #1;
        end
        rst = 1'b0; start0 = 1'b0; bus0.in_valid = 1'b0;

        // Wrap and backpressure on dut1: N=3 from FE, 5 idle cycles mid-pair.
        // Sum 03+A1+B1+A2+B2+A3+B3 = 3FF, so CHK 01.
        @(negedge clk);
        check("wrap_idle_addr", 0, 32'(bus1.pm_addr), 32'h0);
        check("wrap_idle_hold", 0, 32'(hold1), 32'd0);
        @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        send1(8'h03, 0);
        send1(8'hA1, 0);
        send1(8'hB1, 0);
        send1(8'hA2, 0);
        send1(8'hB2, 5);
        send1(8'hA3, 0);
        send1(8'hB3, 0);
        send1(8'h01, 0);

        n = 0;
        @(negedge clk);
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wrap_done", 0, 32'(done1), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wrap_hold_after", 0, 32'(hold1), 32'd0);
        check("wrap_done_count", 0, 32'(done1_cnt), 32'd1);
        check("wrap_err", 0, 32'(err1_seen), 32'd0);

        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        exp_o[0] = 8'hA1; exp_o[1] = 8'hA2; exp_o[2] = 8'hA3;
        exp_d[0] = 8'hB1; exp_d[1] = 8'hB2; exp_d[2] = 8'hB3;
        check("wrap_write_count", 0, 32'(w_addr.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < w_addr.size()) begin
                check("wrap_write", k, 32'({w_addr[k], w_opc[k], w_opd[k]}),
                      32'({exp_a[k], exp_o[k], exp_d[k]}));
                check("wrap_ready_in_write", k, 32'(w_rdy[k]), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
